// File: rtl/spec_free_list.sv
// rtl/spec_free_list.sv - speculative physical-tag free list for rename
// Pops up to 4 tags per cycle, takes back up to 4 released tags, and rewinds to the commit head on recovery.
module spec_free_list #(
  parameter int SIZE_PHYSICAL      = 96,
  parameter int SIZE_PHYSICAL_LOG  = 7,
  parameter int SIZE_RMT           = 32,
  parameter int SIZE_FREE_LIST     = 64,
  parameter int SIZE_FREE_LIST_LOG = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    renameReq_i,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg3_o,
  output logic                          freeListEmpty_o,
  output logic [SIZE_FREE_LIST_LOG:0]   freeCount_o,
  input  logic                          releasedValid0_i,
  input  logic                          releasedValid1_i,
  input  logic                          releasedValid2_i,
  input  logic                          releasedValid3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap3_i,
  input  logic                          recoverFlag_i
);

  localparam int PW = SIZE_FREE_LIST_LOG;
  localparam int TW = SIZE_PHYSICAL_LOG;
  localparam logic [PW:0] LIST_SIZE = (PW+1)'(SIZE_FREE_LIST);
  localparam logic [PW:0] POP_WIDTH = (PW+1)'(4);

  logic [TW-1:0] freeList [SIZE_FREE_LIST];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] commitHeadPtr;
  logic [PW-1:0] tailPtr;
  logic [PW:0]   count;

  logic [3:0]    relValid;
  logic [TW-1:0] relTag [4];
  logic [2:0]    slotOffset [4];
  logic [2:0]    pushCnt;
  logic [2:0]    popCnt;

  // Modulo add on list pointers; the list depth need not be a power of two.
  function automatic logic [PW-1:0] ptrAdd(input logic [PW-1:0] ptr, input logic [2:0] inc);
    logic [PW:0] sum;
    sum = {1'b0, ptr} + {{(PW-2){1'b0}}, inc};
    if (sum >= LIST_SIZE) begin
      sum = sum - LIST_SIZE;
    end
    return sum[PW-1:0];
  endfunction

  assign relValid  = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
  assign relTag[0] = releasedPhyMap0_i;
  assign relTag[1] = releasedPhyMap1_i;
  assign relTag[2] = releasedPhyMap2_i;
  assign relTag[3] = releasedPhyMap3_i;

  // Each valid release lands at tailPtr plus the number of older valid slots.
  always_comb begin
    logic [2:0] acc;
    acc = 3'd0;
    for (int k = 0; k < 4; k++) begin
      slotOffset[k] = acc;
      acc = acc + {2'b00, relValid[k]};
    end
    pushCnt = acc;
  end

  assign freeListEmpty_o = (count < POP_WIDTH);
  assign freeCount_o     = count;
  assign popCnt          = (freeListEmpty_o || recoverFlag_i) ? 3'd0 : renameReq_i;

  assign freeReg0_o = freeList[headPtr];
  assign freeReg1_o = freeList[ptrAdd(headPtr, 3'd1)];
  assign freeReg2_o = freeList[ptrAdd(headPtr, 3'd2)];
  assign freeReg3_o = freeList[ptrAdd(headPtr, 3'd3)];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE_FREE_LIST; i++) begin
        freeList[i] <= TW'((SIZE_RMT + i) % SIZE_PHYSICAL);
      end
      headPtr       <= '0;
      commitHeadPtr <= '0;
      tailPtr       <= '0;
      count         <= LIST_SIZE;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (relValid[k]) begin
          freeList[ptrAdd(tailPtr, slotOffset[k])] <= relTag[k];
        end
      end
      tailPtr       <= ptrAdd(tailPtr, pushCnt);
      // Every release retires one instruction that popped exactly one tag.
      commitHeadPtr <= ptrAdd(commitHeadPtr, pushCnt);
      if (recoverFlag_i) begin
        headPtr <= ptrAdd(commitHeadPtr, pushCnt);
        count   <= LIST_SIZE;
      end else begin
        headPtr <= ptrAdd(headPtr, popCnt);
        count   <= count + {{(PW-2){1'b0}}, pushCnt} - {{(PW-2){1'b0}}, popCnt};
      end
    end
  end

endmodule

// File: tb/tb_spec_free_list.sv
// tb/tb_spec_free_list.sv - scoreboard bench for spec_free_list
// Model keeps free tags and in-flight (popped, not yet retired) tags as two queues.
module tb_spec_free_list;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] renameReq = 3'd0;
  logic [6:0] freeReg0, freeReg1, freeReg2, freeReg3;
  logic       freeListEmpty;
  logic [6:0] freeCount;
  logic       relValid0 = 1'b0, relValid1 = 1'b0, relValid2 = 1'b0, relValid3 = 1'b0;
  logic [6:0] relTag0 = '0, relTag1 = '0, relTag2 = '0, relTag3 = '0;
  logic       recoverFlag = 1'b0;

  typedef struct packed {
    logic [3:0][6:0] tags;
    logic [6:0]      size;
  } expT;

  expT        expQ[$];
  logic [6:0] freeQ[$];
  logic [6:0] inflightQ[$];
  int         checkCount = 0;
  int         errorCount = 0;

  always #5 clk = ~clk;

  spec_free_list dut (
    .clk(clk), .reset(reset), .renameReq_i(renameReq),
    .freeReg0_o(freeReg0), .freeReg1_o(freeReg1), .freeReg2_o(freeReg2), .freeReg3_o(freeReg3),
    .freeListEmpty_o(freeListEmpty), .freeCount_o(freeCount),
    .releasedValid0_i(relValid0), .releasedValid1_i(relValid1),
    .releasedValid2_i(relValid2), .releasedValid3_i(relValid3),
    .releasedPhyMap0_i(relTag0), .releasedPhyMap1_i(relTag1),
    .releasedPhyMap2_i(relTag2), .releasedPhyMap3_i(relTag3),
    .recoverFlag_i(recoverFlag)
  );

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    freeQ.delete();
    inflightQ.delete();
    for (int i = 0; i < 64; i++) freeQ.push_back(7'(32 + i));
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkValue({pfx, "Reg0"}, freeReg0, 32);
    checkValue({pfx, "Reg1"}, freeReg1, 33);
    checkValue({pfx, "Reg2"}, freeReg2, 34);
    checkValue({pfx, "Reg3"}, freeReg3, 35);
    checkValue({pfx, "Count"}, freeCount, 64);
    checkValue({pfx, "Empty"}, freeListEmpty, 0);
  endtask

  // Called at posedge+1: drives one cycle, predicts, then compares after the edge.
  task automatic step(input int req, input logic [3:0] valid, input int t0, input int t1,
                      input int t2, input int t3, input logic rec);
    logic [6:0] tg [4];
    int         popCnt;
    expT        e;
    logic [6:0] obs [4];
    tg[0] = 7'(t0); tg[1] = 7'(t1); tg[2] = 7'(t2); tg[3] = 7'(t3);
    renameReq = 3'(req);
    {relValid3, relValid2, relValid1, relValid0} = valid;
    relTag0 = tg[0]; relTag1 = tg[1]; relTag2 = tg[2]; relTag3 = tg[3];
    recoverFlag = rec;

    popCnt = (freeQ.size() >= 4 && !rec) ? req : 0;
    for (int k = 0; k < 4; k++) begin
      if (valid[k] && inflightQ.size() > 0) void'(inflightQ.pop_front());
    end
    for (int p = 0; p < popCnt; p++) inflightQ.push_back(freeQ.pop_front());
    for (int k = 0; k < 4; k++) begin
      if (valid[k]) freeQ.push_back(tg[k]);
    end
    if (rec) begin
      while (inflightQ.size() > 0) freeQ.push_front(inflightQ.pop_back());
    end
    e = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < freeQ.size()) e.tags[j] = freeQ[j];
    end
    e.size = 7'(freeQ.size());
    expQ.push_back(e);

    @(posedge clk);
    #1;
    e = expQ.pop_front();
    obs[0] = freeReg0; obs[1] = freeReg1; obs[2] = freeReg2; obs[3] = freeReg3;
    for (int j = 0; j < 4; j++) begin
      if (j < int'(e.size)) checkValue($sformatf("freeReg%0d", j), obs[j], e.tags[j]);
    end
    checkValue("freeCount", freeCount, e.size);
    checkValue("freeListEmpty", freeListEmpty, e.size < 7'd4);
    checkValue("countBound", freeCount <= 7'd64, 1);
  endtask

  task automatic asyncResetPulse();
    renameReq = 3'd4;
    {relValid3, relValid2, relValid1, relValid0} = 4'b0000;
    recoverFlag = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkResetOutputs("asyncRst");
    renameReq = 3'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkResetOutputs("rst");
    modelReset();

    step(4, 4'b0000, 0, 0, 0, 0, 0);
    checkValue("firstPopReg0", freeReg0, 36);
    checkValue("firstPopCount", freeCount, 60);

    step(0, 4'b0101, 5, 0, 9, 0, 0);
    checkValue("compactCount", freeCount, 62);

    repeat (14) step(4, 4'b0000, 0, 0, 0, 0, 0);
    step(3, 4'b0000, 0, 0, 0, 0, 0);
    checkValue("drainEmpty", freeListEmpty, 1);
    checkValue("drainReg1", freeReg1, 5);
    checkValue("drainReg2", freeReg2, 9);
    step(2, 4'b0000, 0, 0, 0, 0, 0);
    checkValue("stallCount", freeCount, 3);
    step(0, 4'b0001, 40, 0, 0, 0, 0);
    checkValue("refillEmpty", freeListEmpty, 0);

    asyncResetPulse();

    step(4, 4'b0000, 0, 0, 0, 0, 0);
    step(4, 4'b0000, 0, 0, 0, 0, 0);
    step(0, 4'b0111, 70, 71, 72, 0, 0);
    checkValue("recPreCount", freeCount, 59);
    step(0, 4'b0000, 0, 0, 0, 0, 1);
    checkValue("recCount", freeCount, 64);
    checkValue("recReg0", freeReg0, 35);
    repeat (15) step(4, 4'b0000, 0, 0, 0, 0, 0);
    checkValue("recTail1", freeReg1, 70);
    checkValue("recTail3", freeReg3, 72);

    step(4, 4'b0011, 80, 81, 0, 0, 1);
    checkValue("recBothCount", freeCount, 64);
    checkValue("recBothReg0", freeReg0, 37);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] mask;
      int         avail;
      if (i == 150) begin
        asyncResetPulse();
      end
      mask = 4'b0000;
      avail = inflightQ.size();
      for (int k = 0; k < 4; k++) begin
        if (avail > 0 && $urandom_range(0, 1) == 1) begin
          mask[k] = 1'b1;
          avail--;
        end
      end
      step($urandom_range(0, 4), mask, $urandom_range(0, 95), $urandom_range(0, 95),
           $urandom_range(0, 95), $urandom_range(0, 95), $urandom_range(0, 31) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
